// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;
  typedef enum logic [2:0] {
    HDR0, HDR1, DATA, WRITE, CHECK, DONE, ERR
  } state_e;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_boot_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;

  modport master (output rx_valid, rx_data, input rx_ready, mem_we, mem_addr, mem_wd);
  modport slave  (input rx_valid, rx_data, output rx_ready, mem_we, mem_addr, mem_wd);
endinterface

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word assembler: first byte shifted in lands in [7:0].
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        last_byte,
  output logic        word_full
);
  localparam logic [1:0] LAST = 2'(WORD_BYTES - 1);

  logic [1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt       <= '0;
      word      <= '0;
      word_full <= 1'b0;
    end else if (shift) begin
      word <= {data, word[31:8]};
      cnt  <= cnt + 2'd1;
      if (cnt == LAST) word_full <= 1'b1;
    end
  end

  assign last_byte = (cnt == LAST);
endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a length-prefixed image into instruction memory, then releases core reset.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  imem_boot_loader_if.slave   bus,
  output logic                core_reset,
  output logic                done,
  output logic                err
);
  localparam int IDX_W = $clog2(DEPTH) + 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e AFTER_LAST = CHECK;
`else
  localparam state_e AFTER_LAST = DONE;
`endif

  state_e           state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [7:0]       n_lo;
  logic [CNT_W-1:0] n;
  logic [CNT_W-1:0] hdr_n;
  logic             ready, accept, last_word;
  logic             last_byte, word_full;
  logic [31:0]      word;
  logic             we;
  logic [31:0]      addr, wd;

  assign accept    = bus.rx_valid && ready;
  assign hdr_n     = CNT_W'({bus.rx_data, n_lo});
  assign last_word = (32'(idx) + 32'd1) == 32'(n);

  imem_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (state == WRITE),
    .shift     (state == DATA && accept),
    .data      (bus.rx_data),
    .word      (word),
    .last_byte (last_byte),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= HDR0;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx  <= '0;
      n_lo <= '0;
      n    <= '0;
    end else begin
      if (state == HDR0 && accept) n_lo <= bus.rx_data;
      if (state == HDR1 && accept) n    <= hdr_n;
      if (state == WRITE)          idx  <= idx + 1'b1;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (reset)                        csum <= '0;
    else if (state == DATA && accept) csum <= csum ^ bus.rx_data;
  end
`endif

  always_comb begin
    state_nx = state;
    case (state)
      HDR0:  if (accept) state_nx = HDR1;
      HDR1:
        if (accept) begin
          // Full-width compare so an oversized header cannot alias into range.
          if (hdr_n == '0)                    state_nx = DONE;
          else if (32'(hdr_n) > 32'(DEPTH))   state_nx = ERR;
          else                                state_nx = DATA;
        end
      DATA:  if (accept && last_byte) state_nx = WRITE;
      WRITE: state_nx = last_word ? AFTER_LAST : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: if (accept) state_nx = (bus.rx_data == csum) ? DONE : ERR;
`else
      CHECK: state_nx = ERR;
`endif
      DONE:  state_nx = DONE;
      ERR:   state_nx = ERR;
      default: state_nx = ERR;
    endcase
  end

  always_comb begin
    ready      = 1'b0;
    we         = 1'b0;
    addr       = '0;
    wd         = '0;
    core_reset = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    if (!reset) begin
      case (state)
        HDR0, HDR1, DATA, CHECK: ready = 1'b1;
        WRITE: begin
          we   = word_full;
          addr = 32'(idx) << 2;
          wd   = word;
        end
        DONE: begin
          core_reset = 1'b0;
          done       = 1'b1;
        end
        ERR:     err = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.rx_ready = ready;
  assign bus.mem_we   = we;
  assign bus.mem_addr = addr;
  assign bus.mem_wd   = wd;
endmodule
